// File: rtl/alpha_scale_update_if.sv
// Handshake/data bundle between the alpha-determination FSM, alpha_scale_update and the
// state-vector writeback. The master drives alpha/gate info and observes the result.
interface alpha_scale_update_if #(
    parameter int unsigned NumQubit = 4
);
    logic                   done_alpha;
    logic signed [31:0]     alpha_r;
    logic signed [31:0]     alpha_i;
    logic                   initial_alpha_zero;
    logic [1:0]             reg_gate_type;
    logic [31:0]            reg_qubit_pos;
    logic [0:NumQubit-1]    basis_index_in;

    logic signed [31:0]     amp_out_r;
    logic signed [31:0]     amp_out_i;
    logic [0:NumQubit-1]    basis_index_out;
    logic                   amp_valid;
    logic                   busy;
    logic                   drop_err;

    modport master (
        output done_alpha,
        output alpha_r,
        output alpha_i,
        output initial_alpha_zero,
        output reg_gate_type,
        output reg_qubit_pos,
        output basis_index_in,
        input  amp_out_r,
        input  amp_out_i,
        input  basis_index_out,
        input  amp_valid,
        input  busy,
        input  drop_err
    );

    modport slave (
        input  done_alpha,
        input  alpha_r,
        input  alpha_i,
        input  initial_alpha_zero,
        input  reg_gate_type,
        input  reg_qubit_pos,
        input  basis_index_in,
        output amp_out_r,
        output amp_out_i,
        output basis_index_out,
        output amp_valid,
        output busy,
        output drop_err
    );
endinterface

// File: rtl/alpha_scale_update.sv
// Scales Hadamard alpha by 1/sqrt2 (fixed point, round half up), passes other gates through,
// moves the basis index to its partner when needed and emits a 1-cycle amp_valid pulse.
module alpha_scale_update #(
    parameter int unsigned NumQubit = 4,
    parameter int unsigned FracBits = 16,
    parameter int unsigned InvSqrt2 = 46341
) (
    input logic                  clk,
    input logic                  rst_new,
    alpha_scale_update_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StRnd,
        StOut
    } state_e;

    localparam logic [1:0]         GateHadamard = 2'd0;
    localparam logic signed [63:0] ScaleW       = 64'(InvSqrt2);
    localparam logic signed [63:0] RoundBias    = 64'sd1 <<< (FracBits - 1);

    state_e              state_q, state_d;
    logic signed [31:0]  alpha_r_q, alpha_r_d;
    logic signed [31:0]  alpha_i_q, alpha_i_d;
    logic [31:0]         pos_q, pos_d;
    logic                iaz_q, iaz_d;
    logic [0:NumQubit-1] basis_q, basis_d;
    logic signed [63:0]  prod_r_q, prod_r_d;
    logic signed [63:0]  prod_i_q, prod_i_d;
    logic signed [31:0]  amp_r_q, amp_r_d;
    logic signed [31:0]  amp_i_q, amp_i_d;
    logic [0:NumQubit-1] basis_out_q, basis_out_d;
    logic                amp_valid_q, amp_valid_d;
    logic                drop_err_q, drop_err_d;

    logic signed [63:0]  alpha_ext_r, alpha_ext_i;
    logic signed [31:0]  amp_rnd_r, amp_rnd_i;
    logic [0:NumQubit-1] basis_flip;

    assign alpha_ext_r = 64'(alpha_r_q);
    assign alpha_ext_i = 64'(alpha_i_q);

    // Products are below 2^(FracBits+31), so the low word after the shift is exact.
    assign amp_rnd_r = 32'((prod_r_q + RoundBias) >>> FracBits);
    assign amp_rnd_i = 32'((prod_i_q + RoundBias) >>> FracBits);

    // Out-of-range positions match no bit, leaving the basis unchanged.
    always_comb begin
        basis_flip = basis_q;
        for (int unsigned i = 0; i < NumQubit; i++) begin
            if (iaz_q && (pos_q == 32'(i))) begin
                basis_flip[i] = ~basis_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        alpha_r_d   = alpha_r_q;
        alpha_i_d   = alpha_i_q;
        pos_d       = pos_q;
        iaz_d       = iaz_q;
        basis_d     = basis_q;
        prod_r_d    = prod_r_q;
        prod_i_d    = prod_i_q;
        amp_r_d     = amp_r_q;
        amp_i_d     = amp_i_q;
        basis_out_d = basis_out_q;
        amp_valid_d = 1'b0;
        drop_err_d  = drop_err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.done_alpha) begin
                    alpha_r_d = bus.alpha_r;
                    alpha_i_d = bus.alpha_i;
                    pos_d     = bus.reg_qubit_pos;
                    iaz_d     = bus.initial_alpha_zero;
                    basis_d   = bus.basis_index_in;
                    if (bus.reg_gate_type == GateHadamard) begin
                        state_d = StMul;
                    end else begin
                        amp_r_d     = bus.alpha_r;
                        amp_i_d     = bus.alpha_i;
                        basis_out_d = bus.basis_index_in;
                        state_d     = StOut;
                    end
                end
            end
            StMul: begin
                prod_r_d = alpha_ext_r * ScaleW;
                prod_i_d = alpha_ext_i * ScaleW;
                state_d  = StRnd;
            end
            StRnd: begin
                amp_r_d     = amp_rnd_r;
                amp_i_d     = amp_rnd_i;
                basis_out_d = basis_flip;
                state_d     = StOut;
            end
            StOut: begin
                amp_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A strobe while busy is lost; flag it until the next reset.
        if (bus.done_alpha && (state_q != StIdle)) begin
            drop_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_new) begin
        if (!rst_new) begin
            state_q     <= StIdle;
            alpha_r_q   <= '0;
            alpha_i_q   <= '0;
            pos_q       <= '0;
            iaz_q       <= 1'b0;
            basis_q     <= '0;
            prod_r_q    <= '0;
            prod_i_q    <= '0;
            amp_r_q     <= '0;
            amp_i_q     <= '0;
            basis_out_q <= '0;
            amp_valid_q <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            alpha_r_q   <= alpha_r_d;
            alpha_i_q   <= alpha_i_d;
            pos_q       <= pos_d;
            iaz_q       <= iaz_d;
            basis_q     <= basis_d;
            prod_r_q    <= prod_r_d;
            prod_i_q    <= prod_i_d;
            amp_r_q     <= amp_r_d;
            amp_i_q     <= amp_i_d;
            basis_out_q <= basis_out_d;
            amp_valid_q <= amp_valid_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign bus.amp_out_r       = amp_r_q;
    assign bus.amp_out_i       = amp_i_q;
    assign bus.basis_index_out = basis_out_q;
    assign bus.amp_valid       = amp_valid_q;
    assign bus.busy            = (state_q != StIdle);
    assign bus.drop_err        = drop_err_q;

endmodule

// File: tb/tb_alpha_scale_update.sv
// Directed bench for alpha_scale_update: hand-computed vectors checked with immediate assertions.
module tb_alpha_scale_update;

    logic clk;
    logic rst_new;
    int   n_cmp;
    int   n_bad;

    alpha_scale_update_if #(.NumQubit(4)) bus ();

    alpha_scale_update #(
        .NumQubit (4),
        .FracBits (16),
        .InvSqrt2 (46341)
    ) dut (
        .clk     (clk),
        .rst_new (rst_new),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [1:0] gate, input int ar, input int ai, input logic iaz,
                          input int pos, input logic [3:0] basis);
        bus.done_alpha         = 1'b1;
        bus.reg_gate_type      = gate;
        bus.alpha_r            = ar;
        bus.alpha_i            = ai;
        bus.initial_alpha_zero = iaz;
        bus.reg_qubit_pos      = pos;
        bus.basis_index_in     = basis;
    endtask

    task automatic check_result(input string tag, input int er, input int ei, input logic [3:0] eb);
        check({tag, "_valid"}, 32'(bus.amp_valid), 32'd1);
        check({tag, "_amp_r"}, bus.amp_out_r, er);
        check({tag, "_amp_i"}, bus.amp_out_i, ei);
        check({tag, "_basis"}, 32'(bus.basis_index_out), 32'(eb));
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_new = 1'b0;
        strobe(2'd0, 0, 0, 1'b0, 0, 4'b0000);
        bus.done_alpha = 1'b0;
        tick();
        tick();

        check("rst_amp_r", bus.amp_out_r, 0);
        check("rst_amp_i", bus.amp_out_i, 0);
        check("rst_basis", 32'(bus.basis_index_out), 0);
        check("rst_valid", 32'(bus.amp_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_drop", 32'(bus.drop_err), 0);

        rst_new = 1'b1;
        tick();

        // Hadamard, exact scaling, no basis move
        strobe(2'd0, 131072, -65536, 1'b0, 1, 4'b0010);
        tick();
        bus.done_alpha = 1'b0;
        check("h1_busy", 32'(bus.busy), 1);
        check("h1_v1", 32'(bus.amp_valid), 0);
        tick();
        check("h1_v2", 32'(bus.amp_valid), 0);
        tick();
        check("h1_v3", 32'(bus.amp_valid), 0);
        tick();
        check_result("h1", 92682, -46341, 4'b0010);
        check("h1_idle", 32'(bus.busy), 0);
        tick();
        check("h1_pulse", 32'(bus.amp_valid), 0);
        check("h1_hold", bus.amp_out_r, 92682);

        // Hadamard, rounding of +-1 and basis bit 2 flipped
        strobe(2'd0, 1, -1, 1'b1, 2, 4'b0010);
        tick();
        bus.done_alpha = 1'b0;
        tick();
        tick();
        tick();
        check_result("h2", 1, -1, 4'b0000);

        // Hadamard, out-of-range position leaves basis alone
        strobe(2'd0, 0, 0, 1'b1, 7, 4'b1010);
        tick();
        bus.done_alpha = 1'b0;
        tick();
        tick();
        tick();
        check_result("hpos", 0, 0, 4'b1010);

        // Phase pass-through, iaz ignored
        strobe(2'd1, -5, 7, 1'b1, 0, 4'b1001);
        tick();
        bus.done_alpha = 1'b0;
        check("ph_v0", 32'(bus.amp_valid), 0);
        check("ph_busy", 32'(bus.busy), 1);
        tick();
        check_result("ph", -5, 7, 4'b1001);

        // Overlap: second strobe while busy is dropped
        strobe(2'd0, 65536, 0, 1'b0, 0, 4'b0101);
        tick();
        strobe(2'd1, 999, 999, 1'b1, 0, 4'b1111);
        tick();
        bus.done_alpha = 1'b0;
        check("ov_drop", 32'(bus.drop_err), 1);
        check("ov_busy", 32'(bus.busy), 1);
        tick();
        tick();
        check_result("ov", 46341, 0, 4'b0101);
        tick();
        strobe(2'd2, 3, 4, 1'b1, 1, 4'b0110);
        tick();
        bus.done_alpha = 1'b0;
        tick();
        check_result("ov_next", 3, 4, 4'b0110);
        check("ov_sticky", 32'(bus.drop_err), 1);

        // Back-to-back: new strobe in the amp_valid cycle
        tick();
        strobe(2'd1, 10, -20, 1'b0, 0, 4'b0001);
        tick();
        bus.done_alpha = 1'b0;
        tick();
        check_result("bb1", 10, -20, 4'b0001);
        strobe(2'd0, -131072, 65536, 1'b1, 3, 4'b0001);
        tick();
        bus.done_alpha = 1'b0;
        check("bb_v0", 32'(bus.amp_valid), 0);
        check("bb_busy", 32'(bus.busy), 1);
        tick();
        tick();
        tick();
        check_result("bb2", -92682, 46341, 4'b0000);

        // Reset while in RND aborts the item
        tick();
        strobe(2'd0, 131072, 131072, 1'b1, 0, 4'b1100);
        tick();
        bus.done_alpha = 1'b0;
        tick();
        rst_new = 1'b0;
        #1;
        check("ar_amp_r", bus.amp_out_r, 0);
        check("ar_amp_i", bus.amp_out_i, 0);
        check("ar_basis", 32'(bus.basis_index_out), 0);
        check("ar_busy", 32'(bus.busy), 0);
        check("ar_drop", 32'(bus.drop_err), 0);
        tick();
        rst_new = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ar_novalid", 32'(bus.amp_valid), 0);
        end
        strobe(2'd0, 131072, -65536, 1'b1, 0, 4'b1000);
        tick();
        bus.done_alpha = 1'b0;
        tick();
        tick();
        tick();
        check_result("ar_next", 92682, -46341, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
